// File: rtl/bldc_drive_pkg.sv
// Shared constants for the BLDC drive sequencer: state encoding and state_out width.
package bldc_drive_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 3'd1;
  localparam logic [STATE_W-1:0] ST_STOP  = 3'd2;
  localparam logic [STATE_W-1:0] ST_DWELL = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAULT = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_STOP  = ST_STOP,
    S_DWELL = ST_DWELL,
    S_FAULT = ST_FAULT
  } state_t;

endpackage

// File: rtl/bldc_ramp_tick.sv
// Ramp prescaler: one-cycle tick every RAMP_DIV clocks while run is high.
// clear marks the first cycle of a new state, where the count reads as zero.
module bldc_ramp_tick
  import bldc_drive_pkg::*;
#(
  parameter int unsigned RAMP_DIV = 1000,
  parameter int unsigned CNTW     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick_c
);

  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_eff;

  always_comb begin
    cnt_eff = clear ? '0 : cnt;
    tick_c  = run && (cnt_eff == CNTW'(RAMP_DIV - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_eff + CNTW'(1);
    end
  end

endmodule

// File: rtl/bldc_drive_sequencer.sv
// Supervisory sequencer: rate-limited duty, direction reversal via stop/dwell, latched faults.
// Optional hall-silence stall detection is built when BLDC_STALL_DETECT_EN is defined.
module bldc_drive_sequencer
  import bldc_drive_pkg::*;
#(
  parameter int unsigned DWIDTH       = 10,
  parameter int unsigned RAMP_DIV     = 1000,
  parameter int unsigned RAMP_STEP    = 1,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned STALL_CYCLES = 1000000,
  parameter int unsigned CNTW         = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               dir_req,
  input  logic [DWIDTH-1:0]  potensio_value,
  input  logic               fault_in,
  input  logic               HallA,
  input  logic               HallB,
  input  logic               HallC,
  output logic [DWIDTH-1:0]  duty_cmd,
  output logic               forward,
  output logic               drive_en,
  output logic               busy,
  output logic [STATE_W-1:0] state_out,
  output logic               fault_out,
  output logic               stall_out
);

  localparam int unsigned XW = DWIDTH + 1;
  localparam logic [XW-1:0] STEP_X = XW'(RAMP_STEP);

  state_t          state;
  state_t          prev_state;
  logic [CNTW-1:0] dwell_cnt;
  logic            tick_c;
  logic            stall_c;
  logic [XW-1:0]   duty_x;
  logic [XW-1:0]   pot_x;
  logic [XW-1:0]   diff_x;
  logic [XW-1:0]   step_x;
  logic [DWIDTH-1:0] ramp_c;
  logic [DWIDTH-1:0] stop_c;

  assign state_out = state;

  bldc_ramp_tick #(
    .RAMP_DIV (RAMP_DIV),
    .CNTW     (CNTW)
  ) u_ramp_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != prev_state),
    .run    ((state == S_RUN) || (state == S_STOP)),
    .tick_c (tick_c)
  );

  // One ramp step toward the setpoint, clamped so it never crosses it.
  always_comb begin
    duty_x = {1'b0, duty_cmd};
    pot_x  = {1'b0, potensio_value};
    diff_x = (pot_x > duty_x) ? (pot_x - duty_x) : (duty_x - pot_x);
    step_x = (diff_x < STEP_X) ? diff_x : STEP_X;
    if (pot_x > duty_x) begin
      ramp_c = duty_cmd + step_x[DWIDTH-1:0];
    end else begin
      ramp_c = duty_cmd - step_x[DWIDTH-1:0];
    end
    stop_c = (duty_x > STEP_X) ? (duty_cmd - STEP_X[DWIDTH-1:0]) : '0;
  end

`ifdef BLDC_STALL_DETECT_EN
  logic [2:0]      hall_s1;
  logic [2:0]      hall_s2;
  logic [2:0]      hall_prev;
  logic [CNTW-1:0] stall_cnt;
  logic            hall_edge_c;
  logic            stall_arm_c;

  always_comb begin
    hall_edge_c = (hall_s2 != hall_prev);
    stall_arm_c = (state == S_RUN) && (duty_cmd != '0) && !hall_edge_c;
    stall_c     = stall_arm_c && (stall_cnt == CNTW'(STALL_CYCLES - 1));
  end

  // Hall synchronizer, silence counter and latched stall flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hall_s1   <= '0;
      hall_s2   <= '0;
      hall_prev <= '0;
      stall_cnt <= '0;
      stall_out <= 1'b0;
    end else begin
      hall_s1   <= {HallA, HallB, HallC};
      hall_s2   <= hall_s1;
      hall_prev <= hall_s2;
      stall_cnt <= (stall_arm_c && !stall_c) ? (stall_cnt + CNTW'(1)) : '0;
      if ((state == S_FAULT) && !fault_in && !enable) begin
        stall_out <= 1'b0;
      end else if (stall_c && !fault_in) begin
        stall_out <= 1'b1;
      end
    end
  end
`else
  logic unused_hall;
  assign unused_hall = ^{HallA, HallB, HallC, CNTW'(STALL_CYCLES)};
  assign stall_c     = 1'b0;
  assign stall_out   = 1'b0;
`endif

  // Main sequencer; faults pre-empt every other transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      prev_state <= S_IDLE;
      duty_cmd   <= '0;
      forward    <= 1'b1;
      drive_en   <= 1'b0;
      busy       <= 1'b0;
      fault_out  <= 1'b0;
      dwell_cnt  <= '0;
    end else begin
      prev_state <= state;
      dwell_cnt  <= '0;
      if (fault_in || stall_c) begin
        state     <= S_FAULT;
        duty_cmd  <= '0;
        drive_en  <= 1'b0;
        fault_out <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            duty_cmd <= '0;
            if (enable) begin
              state    <= S_RUN;
              forward  <= dir_req;
              drive_en <= 1'b1;
              busy     <= (potensio_value != '0);
            end else begin
              busy <= 1'b0;
            end
          end
          S_RUN: begin
            if (!enable || (dir_req != forward)) begin
              state <= S_STOP;
              busy  <= 1'b1;
            end else if (tick_c) begin
              duty_cmd <= ramp_c;
              busy     <= (ramp_c != potensio_value);
            end else begin
              busy <= (duty_cmd != potensio_value);
            end
          end
          S_STOP: begin
            busy <= 1'b1;
            if (duty_cmd == '0) begin
              drive_en <= 1'b0;
              state    <= S_DWELL;
            end else if (tick_c) begin
              duty_cmd <= stop_c;
            end
          end
          S_DWELL: begin
            if (dwell_cnt == CNTW'(DWELL_CYCLES - 1)) begin
              if (enable) begin
                state    <= S_RUN;
                forward  <= dir_req;
                drive_en <= 1'b1;
                busy     <= (potensio_value != '0);
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              dwell_cnt <= dwell_cnt + CNTW'(1);
              busy      <= 1'b1;
            end
          end
          S_FAULT: begin
            busy <= 1'b0;
            if (!enable) begin
              state     <= S_IDLE;
              fault_out <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bldc_drive_sequencer.sv
// Self-checking bench for bldc_drive_sequencer: directed vector table, async reset case,
// optional stall case, then randomized traffic against a cycle-level behavioural model.
module tb_bldc_drive_sequencer;

  localparam int DW    = 10;
  localparam int DIV   = 4;
  localparam int STEP  = 8;
  localparam int DWELL = 10;
  localparam int STALL = 64;
  localparam int CW    = 20;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_STOP  = 2;
  localparam int S_DWELL = 3;
  localparam int S_FAULT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          dir_req;
  logic [DW-1:0] pot;
  logic          fault_in;
  logic [2:0]    hall_code;
  logic [DW-1:0] duty_cmd;
  logic          forward;
  logic          drive_en;
  logic          busy;
  logic [2:0]    state_out;
  logic          fault_out;
  logic          stall_out;

  bldc_drive_sequencer #(
    .DWIDTH       (DW),
    .RAMP_DIV     (DIV),
    .RAMP_STEP    (STEP),
    .DWELL_CYCLES (DWELL),
    .STALL_CYCLES (STALL),
    .CNTW         (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .dir_req        (dir_req),
    .potensio_value (pot),
    .fault_in       (fault_in),
    .HallA          (hall_code[2]),
    .HallB          (hall_code[1]),
    .HallC          (hall_code[0]),
    .duty_cmd       (duty_cmd),
    .forward        (forward),
    .drive_en       (drive_en),
    .busy           (busy),
    .state_out      (state_out),
    .fault_out      (fault_out),
    .stall_out      (stall_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state: mode, cycles spent in the mode, and visible outputs.
  int m_st, m_t, m_duty, m_fwd, m_den, m_busy, m_fo, m_so, m_static;
  int hs[3];

  logic [2:0] hall_seq[6];
  int  hall_idx;
  int  hall_cnt;
  bit  hall_auto;

  typedef struct {
    bit en; bit dir; int pot; bit flt; int n;
    int st; int duty; bit den; bit fwd; bit fo; bit bsy;
  } vec_t;
  localparam int NV = 21;
  vec_t vt[NV];

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_st = S_IDLE; m_t = 0; m_duty = 0; m_fwd = 1; m_den = 0;
    m_busy = 0; m_fo = 0; m_so = 0; m_static = 0;
    hs[0] = 0; hs[1] = 0; hs[2] = 0;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void model_edge();
    int  nst, pot_i;
    bit  tick, hedge, stall_hit;
    pot_i = int'(pot);
    tick  = (m_st == S_RUN || m_st == S_STOP) && ((m_t % DIV) == DIV - 1);
    hedge = (hs[1] != hs[2]);
    stall_hit = 1'b0;
`ifdef BLDC_STALL_DETECT_EN
    if (m_st == S_RUN && m_duty != 0 && !hedge) m_static++;
    else m_static = 0;
    stall_hit = (m_static >= STALL);
`endif
    hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = int'(hall_code);
    nst = m_st;
    if (fault_in) begin
      nst = S_FAULT; m_duty = 0; m_den = 0; m_fo = 1;
    end else if (stall_hit) begin
      nst = S_FAULT; m_duty = 0; m_den = 0; m_fo = 1; m_so = 1;
    end else begin
      case (m_st)
        S_IDLE: begin
          m_duty = 0;
          if (enable) begin nst = S_RUN; m_fwd = int'(dir_req); m_den = 1; end
        end
        S_RUN: begin
          if (!enable || int'(dir_req) != m_fwd) nst = S_STOP;
          else if (tick) begin
            if (m_duty < pot_i) m_duty = (m_duty + STEP > pot_i) ? pot_i : m_duty + STEP;
            else if (m_duty > pot_i) m_duty = (m_duty - STEP < pot_i) ? pot_i : m_duty - STEP;
          end
        end
        S_STOP: begin
          if (m_duty == 0) begin m_den = 0; nst = S_DWELL; end
          else if (tick) m_duty = (m_duty > STEP) ? m_duty - STEP : 0;
        end
        S_DWELL: begin
          if (m_t == DWELL - 1) begin
            if (enable) begin nst = S_RUN; m_fwd = int'(dir_req); m_den = 1; end
            else nst = S_IDLE;
          end
        end
        default: begin
          if (!enable) begin nst = S_IDLE; m_fo = 0; m_so = 0; end
        end
      endcase
    end
    m_t  = (nst == m_st) ? m_t + 1 : 0;
    m_st = nst;
    m_busy = (m_st == S_STOP || m_st == S_DWELL || (m_st == S_RUN && m_duty != pot_i)) ? 1 : 0;
  endfunction

  function automatic void check_model();
    chk("duty",  int'(duty_cmd),  m_duty);
    chk("fwd",   int'(forward),   m_fwd);
    chk("den",   int'(drive_en),  m_den);
    chk("busy",  int'(busy),      m_busy);
    chk("state", int'(state_out), m_st);
    chk("fault", int'(fault_out), m_fo);
    chk("stall", int'(stall_out), m_so);
  endfunction

  task automatic step();
    if (hall_auto) begin
      hall_cnt++;
      if (hall_cnt >= 20) begin
        hall_cnt  = 0;
        hall_idx  = (hall_idx + 1) % 6;
        hall_code = hall_seq[hall_idx];
      end
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    hall_seq[0] = 3'b001; hall_seq[1] = 3'b011; hall_seq[2] = 3'b010;
    hall_seq[3] = 3'b110; hall_seq[4] = 3'b100; hall_seq[5] = 3'b101;
    hall_idx = 0; hall_cnt = 0; hall_auto = 1'b1;
    hall_code = hall_seq[0];

    //       en    dir   pot   flt   n    state    duty  den   fwd   fo    busy
    vt[0]  = '{1'b0, 1'b1, 100,  1'b0, 1,   S_IDLE,  0,    1'b0, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 100,  1'b0, 1,   S_RUN,   0,    1'b1, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b1, 100,  1'b0, 4,   S_RUN,   8,    1'b1, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 1'b1, 100,  1'b0, 48,  S_RUN,   100,  1'b1, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 100,  1'b0, 20,  S_RUN,   100,  1'b1, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 100,  1'b0, 1,   S_STOP,  100,  1'b1, 1'b1, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 100,  1'b0, 4,   S_STOP,  92,   1'b1, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 100,  1'b0, 48,  S_STOP,  0,    1'b1, 1'b1, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 100,  1'b0, 1,   S_DWELL, 0,    1'b0, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 100,  1'b0, 10,  S_RUN,   0,    1'b1, 1'b0, 1'b0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 100,  1'b0, 52,  S_RUN,   100,  1'b1, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 0,    1'b0, 52,  S_RUN,   0,    1'b1, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b0, 100,  1'b0, 24,  S_RUN,   48,   1'b1, 1'b0, 1'b0, 1'b1};
    vt[13] = '{1'b1, 1'b0, 100,  1'b1, 1,   S_FAULT, 0,    1'b0, 1'b0, 1'b1, 1'b0};
    vt[14] = '{1'b1, 1'b0, 100,  1'b0, 5,   S_FAULT, 0,    1'b0, 1'b0, 1'b1, 1'b0};
    vt[15] = '{1'b0, 1'b0, 100,  1'b0, 1,   S_IDLE,  0,    1'b0, 1'b0, 1'b0, 1'b0};
    vt[16] = '{1'b1, 1'b1, 1023, 1'b0, 1,   S_RUN,   0,    1'b1, 1'b1, 1'b0, 1'b1};
    vt[17] = '{1'b1, 1'b1, 1023, 1'b0, 512, S_RUN,   1023, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[18] = '{1'b1, 1'b1, 5,    1'b0, 512, S_RUN,   5,    1'b1, 1'b1, 1'b0, 1'b0};
    vt[19] = '{1'b1, 1'b1, 5,    1'b0, 8,   S_RUN,   5,    1'b1, 1'b1, 1'b0, 1'b0};
    vt[20] = '{1'b1, 1'b1, 56,   1'b0, 28,  S_RUN,   56,   1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; enable = 1'b0; dir_req = 1'b1; pot = 10'd100; fault_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      enable = vt[i].en; dir_req = vt[i].dir; pot = DW'(vt[i].pot); fault_in = vt[i].flt;
      repeat (vt[i].n) step();
      fault_in = 1'b0;
      chk($sformatf("v%0d.state", i), int'(state_out), vt[i].st);
      chk($sformatf("v%0d.duty", i),  int'(duty_cmd),  vt[i].duty);
      chk($sformatf("v%0d.den", i),   int'(drive_en),  int'(vt[i].den));
      chk($sformatf("v%0d.fwd", i),   int'(forward),   int'(vt[i].fwd));
      chk($sformatf("v%0d.fault", i), int'(fault_out), int'(vt[i].fo));
      chk($sformatf("v%0d.busy", i),  int'(busy),      int'(vt[i].bsy));
    end

    // Asynchronous reset in the middle of RUN, observed before any clock edge.
    #2 rst = 1'b1; enable = 1'b0;
    #1;
    chk("arst.duty",  int'(duty_cmd),  0);
    chk("arst.fwd",   int'(forward),   1);
    chk("arst.den",   int'(drive_en),  0);
    chk("arst.state", int'(state_out), S_IDLE);
    chk("arst.busy",  int'(busy),      0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();
    chk("arst.idle", int'(state_out), S_IDLE);
    dir_req = 1'b0; enable = 1'b1;
    step();
    chk("rearm.state", int'(state_out), S_RUN);
    chk("rearm.fwd",   int'(forward),   0);

`ifdef BLDC_STALL_DETECT_EN
    hall_auto = 1'b0; pot = 10'd100;
    repeat (200) step();
    chk("stall.state", int'(state_out), S_FAULT);
    chk("stall.flag",  int'(stall_out), 1);
    enable = 1'b0;
    step();
    chk("stall.clear", int'(stall_out), 0);
    hall_auto = 1'b1; enable = 1'b1;
    repeat (300) step();
    chk("nostall.state", int'(state_out), S_RUN);
    chk("nostall.flag",  int'(stall_out), 0);
`endif

    // Randomized traffic with rare faults, toggles and setpoint jumps.
    for (int c = 0; c < 3000; c++) begin
      fault_in = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if (m_st == S_FAULT && $urandom_range(0, 19) == 0) enable = 1'b0;
      if (m_st == S_IDLE && $urandom_range(0, 9) == 0) enable = 1'b1;
      if ($urandom_range(0, 149) == 0) dir_req = ~dir_req;
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 3))
          0: pot = 10'd1023;
          1: pot = DW'($urandom_range(0, 7));
          default: pot = DW'($urandom_range(0, 1023));
        endcase
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
